quad_encoder_angle: RTL

//  Converts quadrature shaft-encoder signals (A/B plus index Z) into an absolute angle of 0..359 degrees.

---
 rtl/enc_pkg.sv | 15 +
 rtl/quad_encoder_angle_if.sv | 13 +
 rtl/enc_input_filter.sv | 30 +++
 rtl/quad_encoder_angle.sv | 103 ++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// enc_pkg: shared quadrature-decoder types, constants and the A/B transition decoder.
package enc_pkg;
  typedef logic [1:0] quad_state_t;
  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ILLEGAL} step_t;
  localparam int DEG_PER_REV = 360;
  localparam int ANGLE_W = 12;
  // CW order on {A,B} is 00->01->11->10->00; every other change of both bits is illegal
  function automatic step_t quad_decode(input quad_state_t prev, input quad_state_t cur);
    quad_state_t cw;
    quad_state_t ccw;
    cw = {prev[0], ~prev[1]};
    ccw = {~prev[0], prev[1]};
    return (cur == prev) ? STEP_NONE : (cur == cw) ? STEP_UP : (cur == ccw) ? STEP_DOWN : STEP_ILLEGAL;
  endfunction
endpackage

// File: rtl/quad_encoder_angle_if.sv
// quad_encoder_angle_if: encoder pins in, display-side angle/strobe/status out.
interface quad_encoder_angle_if;
  import enc_pkg::*;
  logic enc_a;
  logic enc_b;
  logic enc_z;
  logic [ANGLE_W-1:0] angle;
  logic write;
  logic dir;
  logic quad_err;
  modport master (output enc_a, enc_b, enc_z, input angle, write, dir, quad_err);
  modport slave (input enc_a, enc_b, enc_z, output angle, write, dir, quad_err);
endinterface

// File: rtl/enc_input_filter.sv
// enc_input_filter: synchroniser chain plus a level filter needing FILTER_CYCLES equal samples.
module enc_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level
);
  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic r_level;
  logic w_synced;
  logic w_accept;
  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_accept = (w_synced != r_level) && (r_cnt == CNT_W'(FILTER_CYCLES - 1));
  assign o_level = r_level;
  always_ff @(posedge clk)
    if (rst) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, i_pin});
      r_cnt <= (w_synced == r_level || w_accept) ? '0 : r_cnt + 1'b1;
      r_level <= w_accept ? w_synced : r_level;
    end
endmodule

// File: rtl/quad_encoder_angle.sv
// quad_encoder_angle: x4 quadrature decode, exact fractional scaling to 0..359 degrees,
// index zeroing and a periodic write strobe carrying an angle snapshot.
module quad_encoder_angle
  import enc_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int UPDATE_HZ = 30,
  parameter int COUNTS_PER_REV = 1440,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  quad_encoder_angle_if.slave bus
);
  localparam int UPDATE_DIV = CLK_HZ / UPDATE_HZ;
  localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int FRAC_W = $clog2(COUNTS_PER_REV + DEG_PER_REV);
  localparam int LIVE_W = 9;
  localparam logic [LIVE_W-1:0] DEG_MAX = LIVE_W'(DEG_PER_REV - 1);
  logic w_a;
  logic w_b;
  logic w_z;
  quad_state_t w_ab;
  step_t w_step;
  logic w_idx;
  logic w_tc;
  logic w_up_wrap;
  logic w_dn_wrap;
  logic [FRAC_W-1:0] w_up_sum;
  logic [FRAC_W-1:0] w_frac_nxt;
  logic [LIVE_W-1:0] w_live_inc;
  logic [LIVE_W-1:0] w_live_dec;
  logic [LIVE_W-1:0] w_live_nxt;
  quad_state_t r_prev;
  logic r_primed;
  logic r_z_d;
  logic [FRAC_W-1:0] r_frac;
  logic [LIVE_W-1:0] r_live;
  logic [LIVE_W-1:0] r_angle;
  logic [DIV_W-1:0] r_div;
  logic r_write;
  logic r_dir;
  logic r_err;
  enc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_flt_a (
    .clk(clk), .rst(rst), .i_pin(bus.enc_a), .o_level(w_a)
  );
  enc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_flt_b (
    .clk(clk), .rst(rst), .i_pin(bus.enc_b), .o_level(w_b)
  );
  enc_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_CYCLES(FILTER_CYCLES)) u_flt_z (
    .clk(clk), .rst(rst), .i_pin(bus.enc_z), .o_level(w_z)
  );
  // Each count adds 360/CPR degree: accumulate 360 per count in units of 1/CPR degree
  always_comb begin
    w_ab = {w_a, w_b};
    w_step = r_primed ? quad_decode(r_prev, w_ab) : STEP_NONE;
    w_idx = w_z & ~r_z_d;
    w_tc = r_div == DIV_W'(UPDATE_DIV - 1);
    w_up_sum = r_frac + FRAC_W'(DEG_PER_REV);
    w_up_wrap = w_up_sum >= FRAC_W'(COUNTS_PER_REV);
    w_dn_wrap = r_frac < FRAC_W'(DEG_PER_REV);
    w_live_inc = (r_live == DEG_MAX) ? '0 : r_live + 1'b1;
    w_live_dec = (r_live == '0) ? DEG_MAX : r_live - 1'b1;
    w_frac_nxt = w_idx ? '0 :
                 (w_step == STEP_UP) ? (w_up_wrap ? w_up_sum - FRAC_W'(COUNTS_PER_REV) : w_up_sum) :
                 (w_step == STEP_DOWN) ? (w_dn_wrap ? r_frac + FRAC_W'(COUNTS_PER_REV - DEG_PER_REV)
                                                    : r_frac - FRAC_W'(DEG_PER_REV)) :
                 r_frac;
    w_live_nxt = w_idx ? '0 :
                 (w_step == STEP_UP && w_up_wrap) ? w_live_inc :
                 (w_step == STEP_DOWN && w_dn_wrap) ? w_live_dec :
                 r_live;
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_prev <= '0;
      r_primed <= 1'b0;
      r_z_d <= 1'b0;
      r_frac <= '0;
      r_live <= '0;
      r_angle <= '0;
      r_div <= '0;
      r_write <= 1'b0;
      r_dir <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_prev <= w_ab;
      r_primed <= 1'b1;
      r_z_d <= w_z;
      r_frac <= w_frac_nxt;
      r_live <= w_live_nxt;
      r_dir <= (w_step == STEP_UP) ? 1'b1 : (w_step == STEP_DOWN) ? 1'b0 : r_dir;
      r_err <= r_err | (w_step == STEP_ILLEGAL);
      r_div <= w_tc ? '0 : r_div + 1'b1;
      r_write <= w_tc;
      r_angle <= w_tc ? w_live_nxt : r_angle;
    end
  assign bus.angle = ANGLE_W'(r_angle);
  assign bus.write = r_write;
  assign bus.dir = r_dir;
  assign bus.quad_err = r_err;
endmodule
